// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the writeback/commit stage: result-source encoding,
// exception codes, FSM state type and the ecode classification helpers that
// decide which exception CSRs get written.
package wb_commit_stage_pkg;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_CSR  = 2'b01;
  localparam logic [1:0] SRC_DIV  = 2'b10;
  localparam logic [1:0] SRC_LOAD = 2'b11;

  localparam int ECODE_BITS = 7;
  typedef logic [ECODE_BITS-1:0] ecode_t;

  localparam ecode_t ECODE_INT  = 7'h00;
  localparam ecode_t ECODE_PIL  = 7'h01;
  localparam ecode_t ECODE_PIS  = 7'h02;
  localparam ecode_t ECODE_PIF  = 7'h03;
  localparam ecode_t ECODE_PME  = 7'h04;
  localparam ecode_t ECODE_PPI  = 7'h07;
  localparam ecode_t ECODE_ADEF = 7'h08;
  localparam ecode_t ECODE_ALE  = 7'h09;
  localparam ecode_t ECODE_SYS  = 7'h0B;
  localparam ecode_t ECODE_BRK  = 7'h0C;
  localparam ecode_t ECODE_INE  = 7'h0D;
  localparam ecode_t ECODE_TLBR = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXC  = 2'd2
  } state_e;

  // TLB-related faults also load TLBEHI.VPPN from the faulting address.
  function automatic logic is_vppn_ecode(input ecode_t e);
    return (e == ECODE_PIL) || (e == ECODE_PIS) || (e == ECODE_PIF) ||
           (e == ECODE_PME) || (e == ECODE_PPI) || (e == ECODE_TLBR);
  endfunction

  function automatic logic is_badv_ecode(input ecode_t e);
    return is_vppn_ecode(e) || (e == ECODE_ADEF) || (e == ECODE_ALE);
  endfunction

endpackage

// File: rtl/wb_exc_arbiter.sv
// Oldest-exception priority encoder for one issue bundle.
// Ports: lane_valid_i/exc_i/ecode_i/badv_i/pc_i per lane, irq_i pending
// interrupt; exc_o any exception, keep_o lanes older than the winner,
// ecode_o/badv_o/era_o of the winning lane (interrupt: ecode 0, era = pc0).
module wb_exc_arbiter #(
  parameter int LANES   = 2,
  parameter int XLEN    = 32,
  parameter int ECODE_W = 7
) (
  input  logic [LANES-1:0]         lane_valid_i,
  input  logic [LANES-1:0]         exc_i,
  input  logic [LANES*ECODE_W-1:0] ecode_i,
  input  logic [LANES*XLEN-1:0]    badv_i,
  input  logic [LANES*XLEN-1:0]    pc_i,
  input  logic                     irq_i,
  output logic                     exc_o,
  output logic [LANES-1:0]         keep_o,
  output logic [ECODE_W-1:0]       ecode_o,
  output logic [XLEN-1:0]          badv_o,
  output logic [XLEN-1:0]          era_o
);

  // An interrupt claims lane 0 up front, so no lane survives and no lane
  // exception can take over. Otherwise the first flagged lane wins and
  // keep_o drops from that lane upward.
  always_comb begin
    exc_o   = irq_i;
    keep_o  = '0;
    ecode_o = '0;
    badv_o  = '0;
    era_o   = irq_i ? pc_i[XLEN-1:0] : '0;
    for (int i = 0; i < LANES; i++) begin
      if (!exc_o && lane_valid_i[i] && exc_i[i]) begin
        exc_o   = 1'b1;
        ecode_o = ecode_i[i*ECODE_W +: ECODE_W];
        badv_o  = badv_i[i*XLEN +: XLEN];
        era_o   = pc_i[i*XLEN +: XLEN];
      end
      keep_o[i] = !exc_o;
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// N-lane writeback/commit stage between EX2 and the register file / CSR
// exception logic. Accepts one bundle, optionally waits for the shared
// long-latency result, then commits the lanes older than the oldest
// exception in a single registered cycle together with the exception pulse.
// Ports: clk/aresetn; in_* issue bundle with in_valid/in_ready/flush_in;
// irq; long_valid/long_data long-latency return; eentry/tlbrentry vectors;
// wb_* register-file write; exc_* exception CSR controls + redirect_pc;
// debug_* retired-instruction trace.
//
// state   | meaning
// IDLE    | ready for a bundle
// WAIT    | bundle latched, waiting for long_valid
// EXC     | exception pulse cycle, not ready
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int XLEN    = 32,
  parameter int ECODE_W = 7
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     flush_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_valid,
  input  logic [LANES*XLEN-1:0]    in_pc,
  input  logic [LANES*32-1:0]      in_inst,
  input  logic [LANES*2-1:0]       in_src,
  input  logic [LANES*XLEN-1:0]    in_alu_data,
  input  logic [LANES*5-1:0]       in_rd,
  input  logic [LANES-1:0]         in_we,
  input  logic [LANES-1:0]         in_exc,
  input  logic [LANES*ECODE_W-1:0] in_ecode,
  input  logic [LANES*XLEN-1:0]    in_badv,
  input  logic                     irq,
  input  logic                     long_valid,
  input  logic [XLEN-1:0]          long_data,
  input  logic [XLEN-1:0]          eentry,
  input  logic [XLEN-1:0]          tlbrentry,
  output logic [LANES-1:0]         wb_we,
  output logic [LANES*5-1:0]       wb_rd,
  output logic [LANES*XLEN-1:0]    wb_data,
  output logic                     exc_valid,
  output logic [ECODE_W-1:0]       exc_ecode,
  output logic [XLEN-1:0]          exc_era,
  output logic [XLEN-1:0]          exc_badv,
  output logic                     exc_wen_badv,
  output logic                     exc_wen_vppn,
  output logic                     exc_tlbr,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [LANES-1:0]         debug_valid,
  output logic [LANES*XLEN-1:0]    debug_pc,
  output logic [LANES*32-1:0]      debug_inst
);

  state_e state_q, state_d;
  logic   accept, waiting, fire, exc_fire, s_tlbr;

  logic               arb_exc;
  logic [LANES-1:0]   arb_keep;
  logic [ECODE_W-1:0] arb_ecode;
  logic [XLEN-1:0]    arb_badv, arb_era;

  wb_exc_arbiter #(.LANES(LANES), .XLEN(XLEN), .ECODE_W(ECODE_W)) u_arb (
    .lane_valid_i (in_lane_valid),
    .exc_i        (in_exc),
    .ecode_i      (in_ecode),
    .badv_i       (in_badv),
    .pc_i         (in_pc),
    .irq_i        (irq),
    .exc_o        (arb_exc),
    .keep_o       (arb_keep),
    .ecode_o      (arb_ecode),
    .badv_o       (arb_badv),
    .era_o        (arb_era)
  );

  // Candidate commit built from the incoming bundle; squashed lanes are zeroed.
  logic [LANES-1:0]      c_dbg, c_we, c_long;
  logic [LANES*5-1:0]    c_rd;
  logic [LANES*XLEN-1:0] c_data, c_pc;
  logic [LANES*32-1:0]   c_inst;

  always_comb begin
    c_dbg  = in_lane_valid & arb_keep;
    c_we   = '0;
    c_long = '0;
    c_rd   = '0;
    c_data = '0;
    c_pc   = '0;
    c_inst = '0;
    for (int i = 0; i < LANES; i++) begin
      if (c_dbg[i]) begin
        c_we[i]               = in_we[i] && (in_rd[i*5 +: 5] != 5'd0);
        c_long[i]             = in_src[i*2 +: 2] != SRC_ALU;
        c_rd[i*5 +: 5]        = in_rd[i*5 +: 5];
        c_data[i*XLEN +: XLEN] = in_alu_data[i*XLEN +: XLEN];
        c_pc[i*XLEN +: XLEN]   = in_pc[i*XLEN +: XLEN];
        c_inst[i*32 +: 32]    = in_inst[i*32 +: 32];
      end
    end
  end

  // Bundle held across WAIT.
  logic [LANES-1:0]      b_dbg_q, b_we_q, b_long_q;
  logic [LANES*5-1:0]    b_rd_q;
  logic [LANES*XLEN-1:0] b_data_q, b_pc_q;
  logic [LANES*32-1:0]   b_inst_q;
  logic                  b_exc_q;
  logic [ECODE_W-1:0]    b_ecode_q;
  logic [XLEN-1:0]       b_badv_q, b_era_q;

  // Commit source: the held bundle when returning from WAIT, else the
  // incoming one. Only the held bundle can carry a long lane at fire time.
  logic [LANES-1:0]      s_dbg, s_we;
  logic [LANES*5-1:0]    s_rd;
  logic [LANES*XLEN-1:0] s_data, s_pc;
  logic [LANES*32-1:0]   s_inst;
  logic                  s_exc;
  logic [ECODE_W-1:0]    s_ecode;
  logic [XLEN-1:0]       s_badv, s_era;

  assign in_ready = (state_q == ST_IDLE);
  assign waiting  = (state_q == ST_WAIT);
  assign accept   = in_valid && in_ready && !flush_in;

  always_comb begin
    s_dbg   = waiting ? b_dbg_q   : c_dbg;
    s_we    = waiting ? b_we_q    : c_we;
    s_rd    = waiting ? b_rd_q    : c_rd;
    s_data  = waiting ? b_data_q  : c_data;
    s_pc    = waiting ? b_pc_q    : c_pc;
    s_inst  = waiting ? b_inst_q  : c_inst;
    s_exc   = waiting ? b_exc_q   : arb_exc;
    s_ecode = waiting ? b_ecode_q : arb_ecode;
    s_badv  = waiting ? b_badv_q  : arb_badv;
    s_era   = waiting ? b_era_q   : arb_era;
    for (int i = 0; i < LANES; i++) begin
      if (waiting && b_long_q[i]) s_data[i*XLEN +: XLEN] = long_data;
    end
  end

  assign fire     = (in_ready && accept && (c_long == '0)) || (waiting && long_valid);
  assign exc_fire = fire && s_exc;
  assign s_tlbr   = (ecode_t'(s_ecode) == ECODE_TLBR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (c_long != '0) state_d = ST_WAIT;
        else if (arb_exc) state_d = ST_EXC;
      end
      ST_WAIT: if (long_valid) state_d = b_exc_q ? ST_EXC : ST_IDLE;
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      b_dbg_q   <= '0;
      b_we_q    <= '0;
      b_long_q  <= '0;
      b_rd_q    <= '0;
      b_data_q  <= '0;
      b_pc_q    <= '0;
      b_inst_q  <= '0;
      b_exc_q   <= 1'b0;
      b_ecode_q <= '0;
      b_badv_q  <= '0;
      b_era_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        b_dbg_q   <= c_dbg;
        b_we_q    <= c_we;
        b_long_q  <= c_long;
        b_rd_q    <= c_rd;
        b_data_q  <= c_data;
        b_pc_q    <= c_pc;
        b_inst_q  <= c_inst;
        b_exc_q   <= arb_exc;
        b_ecode_q <= arb_ecode;
        b_badv_q  <= arb_badv;
        b_era_q   <= arb_era;
      end
    end
  end

  // Registered outputs: valid for exactly one cycle after a fire, else 0.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wb_we        <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      debug_valid  <= '0;
      debug_pc     <= '0;
      debug_inst   <= '0;
      exc_valid    <= 1'b0;
      exc_ecode    <= '0;
      exc_era      <= '0;
      exc_badv     <= '0;
      exc_wen_badv <= 1'b0;
      exc_wen_vppn <= 1'b0;
      exc_tlbr     <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      wb_we        <= fire ? s_we   : '0;
      wb_rd        <= fire ? s_rd   : '0;
      wb_data      <= fire ? s_data : '0;
      debug_valid  <= fire ? s_dbg  : '0;
      debug_pc     <= fire ? s_pc   : '0;
      debug_inst   <= fire ? s_inst : '0;
      exc_valid    <= exc_fire;
      exc_ecode    <= exc_fire ? s_ecode : '0;
      exc_era      <= exc_fire ? s_era   : '0;
      exc_badv     <= exc_fire ? s_badv  : '0;
      exc_wen_badv <= exc_fire && is_badv_ecode(ecode_t'(s_ecode));
      exc_wen_vppn <= exc_fire && is_vppn_ecode(ecode_t'(s_ecode));
      exc_tlbr     <= exc_fire && s_tlbr;
      redirect_pc  <= exc_fire ? (s_tlbr ? tlbrentry : eentry) : '0;
    end
  end

endmodule
